rsb_ctrl: RTL and testbench
===========================

Name: rsb_ctrl

Overview:
- Front-end control stage directly upstream of the 32-entry return stack buffer (rsb32).
- Converts fetch-stage predecoded call/return events into rsb32 push/pop strobes and tracks valid occupancy.
- Suppresses pops and predictions when the stack is empty.
- Serialises call-and-return instructions into pop-then-push, because rsb32 must never see push and pop in the same cycle.
- Supplies the predicted return target to next-PC select.

Parameters:
- DEPTH, 32, RSB entry count; must equal rsb32 depth.
- ADDR_W, 64, address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- br_valid_i  input  1  predecoded control-flow instruction presented.
- br_ready_o  output  1  instruction accepted this cycle when br_valid_i=1.
- br_pc_i  input  ADDR_W  PC of presented instruction.
- br_is_call_i  input  1  instruction is a call (link write).
- br_is_ret_i  input  1  instruction is a return.
- br_cmp_i  input  1  1 = 2-byte compressed encoding, 0 = 4-byte.
- flush_i  input  1  pipeline redirect; invalidate all entries.
- rsb_top_i  input  ADDR_W  rsb32 top_o.
- push_o  output  1  rsb32 push_i.
- push_addr_o  output  ADDR_W  rsb32 push_addr_i.
- pop_o  output  1  rsb32 pop_i.
- ret_pred_valid_o  output  1  return target prediction valid this cycle.
- ret_target_o  output  ADDR_W  predicted return target.
- occ_o  output  $clog2(DEPTH)+1  valid entry count, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, occ=0, latched push address=0.
- While rst_n=0: push_o, pop_o, ret_pred_valid_o and br_ready_o are 0; ret_target_o, push_addr_o and occ_o are 0.
- Output timing: strobes are combinational from inputs and state, same cycle as acceptance. rsb32 updates on the following edge, so rsb_top_i is current next cycle. No forwarding is required.
- Link address: pc + (br_cmp_i ? 2 : 4), modulo 2^ADDR_W (wraps silently).
- FSM states: IDLE, PUSH_PEND.
- IDLE: br_ready_o=1. An accept is br_valid_i & ~flush_i.
  - Call only: push_o=1, push_addr_o=link. occ increments, saturating at DEPTH. On a full-stack push, rsb32 overwrites the oldest entry; occ stays DEPTH.
  - Ret only, occ>0: pop_o=1, ret_pred_valid_o=1, ret_target_o=rsb_top_i, occ decrements.
  - Ret only, occ=0: pop_o=0, ret_pred_valid_o=0, occ stays 0.
  - Call and ret together: pop as above if occ>0. Latch link, go to PUSH_PEND. push_o=0 this cycle.
  - Neither flag, or br_valid_i=0: no strobes.
- PUSH_PEND: br_ready_o=0. push_o=1, push_addr_o=latched link, occ increments (saturating). Next state IDLE.
- flush_i: highest priority.
  - Forces br_ready_o=0 and all strobes to 0 in that cycle.
  - Next state: occ=0, state=IDLE; a pending push is discarded.
  - rsb32 pointer is not touched; stale entries are masked by occ=0.
- Invariant: push_o & pop_o is never 1 in the same cycle. Assert this in simulation.
- Non-ret cycles: ret_target_o = rsb_top_i regardless of valid. Consumers qualify with ret_pred_valid_o.
- Reset asserted mid-PUSH_PEND: the pending push is lost; occ=0.

Decomposition:
- bp_pkg holds:
  - RSB_DEPTH=32 (shared with rsb32).
  - RSB_OCC_W.
  - rsb_ctrl_state_e {IDLE, PUSH_PEND}.
  - Link-increment constants INST_LEN_STD=4, INST_LEN_CMP=2.
- No sub-module. The occupancy counter and 2-state FSM stay inline. Integration test instantiates rsb_ctrl driving rsb32.

Test Plan:
- Call then ret: call pc=0x1000, 4-byte; next cycle ret. Required: cycle0 push_o=1, push_addr_o=0x1004, occ=1. Cycle1 pop_o=1, ret_pred_valid_o=1, ret_target_o=0x1004, occ=0.
- Compressed link with wrap: call pc=0xFFFF_FFFF_FFFF_FFFE, br_cmp_i=1. Required: push_addr_o=0x0, no error.
- Empty pop: ret with occ=0. Required: pop_o=0, ret_pred_valid_o=0, occ stays 0, br_ready_o=1.
- Overflow: 33 calls at pc=0x100*k. Required: occ saturates at 32. Then 32 rets predict 0x2104 down to 0x204. The 33rd ret gives ret_pred_valid_o=0.
- Call+ret: occ=1 with top 0x1004; call+ret at pc=0x2000. Required: cycle0 pop_o=1, target 0x1004, br_ready_o=1. Cycle1 push_o=1, push_addr_o=0x2004, br_ready_o=0, occ=1. Cycle2 br_ready_o=1.
- Flush: flush_i during PUSH_PEND with occ=3. Required: push_o=0 that cycle; next cycle occ=0, state IDLE; a following ret is not predicted.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-prediction constants and types for the return stack front end.
package bp_pkg;

  localparam int RSB_DEPTH    = 32;
  localparam int RSB_OCC_W    = $clog2(RSB_DEPTH) + 1;
  localparam int INST_LEN_STD = 4;
  localparam int INST_LEN_CMP = 2;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    PUSH_PEND = 1'b1
  } rsb_ctrl_state_e;

endpackage

// File: rtl/rsb_ctrl.sv
// Return stack buffer controller: turns call/return events into rsb32 push/pop
// strobes, tracks valid occupancy and supplies the predicted return target.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | accepting instructions; calls push, returns pop when occ>0
// PUSH_PEND | second half of a call+return; push the latched link address
module rsb_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH  = RSB_DEPTH,
  parameter int ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       br_valid_i,
  output logic                       br_ready_o,
  input  logic [ADDR_W-1:0]          br_pc_i,
  input  logic                       br_is_call_i,
  input  logic                       br_is_ret_i,
  input  logic                       br_cmp_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          rsb_top_i,
  output logic                       push_o,
  output logic [ADDR_W-1:0]          push_addr_o,
  output logic                       pop_o,
  output logic                       ret_pred_valid_o,
  output logic [ADDR_W-1:0]          ret_target_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int               OCC_W   = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  rsb_ctrl_state_e   state_q, state_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [ADDR_W-1:0] link;
  logic              accept;
  logic              do_push;
  logic              do_pop;

  // Link address wraps modulo 2^ADDR_W by construction of the adder width.
  assign link = br_pc_i + (br_cmp_i ? ADDR_W'(INST_LEN_CMP) : ADDR_W'(INST_LEN_STD));

  assign accept  = (state_q == IDLE) & br_valid_i & ~flush_i;
  assign do_pop  = accept & br_is_ret_i & (occ_q != '0);
  assign do_push = (accept & br_is_call_i & ~br_is_ret_i) |
                   ((state_q == PUSH_PEND) & ~flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      occ_q   <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      link_q  <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    link_d  = link_q;
    if (flush_i) begin
      // rsb32 pointer is left alone; occ=0 masks its stale contents.
      state_d = IDLE;
      occ_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept & br_is_call_i & br_is_ret_i) begin
            state_d = PUSH_PEND;
            link_d  = link;
          end
        end
        PUSH_PEND: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
      if (do_pop) begin
        occ_d = occ_q - OCC_ONE;
      end else if (do_push && (occ_q != OCC_MAX)) begin
        occ_d = occ_q + OCC_ONE;
      end
    end
  end

  always_comb begin
    br_ready_o       = 1'b0;
    push_o           = 1'b0;
    push_addr_o      = '0;
    pop_o            = 1'b0;
    ret_pred_valid_o = 1'b0;
    ret_target_o     = '0;
    occ_o            = '0;
    if (rst_n) begin
      br_ready_o       = (state_q == IDLE) & ~flush_i;
      push_o           = do_push;
      push_addr_o      = (state_q == PUSH_PEND) ? link_q : link;
      pop_o            = do_pop;
      ret_pred_valid_o = do_pop;
      ret_target_o     = rsb_top_i;
      occ_o            = occ_q;
    end
  end

  a_no_push_and_pop: assert property (@(posedge clk) disable iff (!rst_n) !(push_o && pop_o));

endmodule

// File: tb/tb_rsb_ctrl.sv
// Bench for rsb_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based stack model.
module tb_rsb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [63:0] br_pc_i;
  logic        br_is_call_i;
  logic        br_is_ret_i;
  logic        br_cmp_i;
  logic        flush_i;
  logic [63:0] rsb_top_i;
  logic        push_o;
  logic [63:0] push_addr_o;
  logic        pop_o;
  logic        ret_pred_valid_o;
  logic [63:0] ret_target_o;
  logic [5:0]  occ_o;

  int n_checks = 0;
  int n_errors = 0;

  rsb_ctrl #(.DEPTH(32), .ADDR_W(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .br_valid_i       (br_valid_i),
    .br_ready_o       (br_ready_o),
    .br_pc_i          (br_pc_i),
    .br_is_call_i     (br_is_call_i),
    .br_is_ret_i      (br_is_ret_i),
    .br_cmp_i         (br_cmp_i),
    .flush_i          (flush_i),
    .rsb_top_i        (rsb_top_i),
    .push_o           (push_o),
    .push_addr_o      (push_addr_o),
    .pop_o            (pop_o),
    .ret_pred_valid_o (ret_pred_valid_o),
    .ret_target_o     (ret_target_o),
    .occ_o            (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rsb32 stand-in: circular buffer, push overwrites oldest when full.
  logic [63:0] rsb_mem [32];
  logic [4:0]  rsb_ptr = 5'd0;
  always @(posedge clk) begin
    if (push_o) begin
      rsb_mem[rsb_ptr + 5'd1] <= push_addr_o;
      rsb_ptr <= rsb_ptr + 5'd1;
    end else if (pop_o) begin
      rsb_ptr <= rsb_ptr - 5'd1;
    end
  end
  assign rsb_top_i = rsb_mem[rsb_ptr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the valid part of the stack as a queue, newest at the back.
  logic [63:0] mq[$];
  bit          pend = 1'b0;
  logic [63:0] pend_addr = 64'd0;

  always @(negedge clk) begin
    logic [63:0] link, e_addr, e_tgt;
    bit e_push, e_pop, e_rdy, was_pend;
    if (!rst_n) begin
      chk("m_rst_ready", br_ready_o, 0);
      chk("m_rst_push", push_o, 0);
      chk("m_rst_pop", pop_o, 0);
      chk("m_rst_pv", ret_pred_valid_o, 0);
      chk("m_rst_tgt", ret_target_o, 0);
      chk("m_rst_paddr", push_addr_o, 0);
      chk("m_rst_occ", occ_o, 0);
      mq.delete();
      pend = 1'b0;
    end else begin
      e_push = 0; e_pop = 0; e_rdy = 0; e_addr = 0; e_tgt = 0;
      was_pend = pend;
      link = br_pc_i + (br_cmp_i ? 64'd2 : 64'd4);
      chk("m_occ", occ_o, 64'(mq.size()));
      if (flush_i) begin
        e_rdy = 0;
      end else if (was_pend) begin
        e_push = 1; e_addr = pend_addr;
      end else begin
        e_rdy = 1;
        if (br_valid_i) begin
          if (br_is_ret_i && mq.size() > 0) begin
            e_pop = 1; e_tgt = mq[$];
          end
          if (br_is_call_i && !br_is_ret_i) begin
            e_push = 1; e_addr = link;
          end
        end
      end
      chk("m_ready", br_ready_o, 64'(e_rdy));
      chk("m_push", push_o, 64'(e_push));
      chk("m_pop", pop_o, 64'(e_pop));
      chk("m_pv", ret_pred_valid_o, 64'(e_pop));
      if (e_push) chk("m_paddr", push_addr_o, e_addr);
      if (e_pop) chk("m_tgt", ret_target_o, e_tgt);
      else       chk("m_tgt_pass", ret_target_o, rsb_top_i);
      if (flush_i) begin
        mq.delete();
        pend = 1'b0;
      end else begin
        if (e_pop) void'(mq.pop_back());
        if (was_pend) pend = 1'b0;
        if (e_push) begin
          if (mq.size() == 32) void'(mq.pop_front());
          mq.push_back(e_addr);
        end
        if (!was_pend && br_valid_i && br_is_call_i && br_is_ret_i) begin
          pend = 1'b1;
          pend_addr = link;
        end
      end
    end
  end

  task automatic drv(input bit v, input logic [63:0] pc, input bit c, input bit r,
                     input bit cmp, input bit f);
    br_valid_i = v; br_pc_i = pc; br_is_call_i = c; br_is_ret_i = r;
    br_cmp_i = cmp; flush_i = f;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1, 64'h1000, 1, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", br_ready_o, 0);
      chk("rst_push", push_o, 0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("init_occ", occ_o, 0); chk("init_ready", br_ready_o, 1);
    cyc;

    // call then ret
    drv(1, 64'h1000, 1, 0, 0, 0);
    @(negedge clk); chk("c1_push", push_o, 1); chk("c1_addr", push_addr_o, 64'h1004);
    cyc;
    drv(1, 64'h1010, 0, 1, 0, 0);
    @(negedge clk); chk("r1_pop", pop_o, 1); chk("r1_pv", ret_pred_valid_o, 1);
    chk("r1_tgt", ret_target_o, 64'h1004); chk("r1_occ", occ_o, 1);
    cyc;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("r1_occ_after", occ_o, 0);
    cyc;

    // empty pop
    drv(1, 64'h3000, 0, 1, 0, 0);
    @(negedge clk); chk("ep_pop", pop_o, 0); chk("ep_pv", ret_pred_valid_o, 0);
    chk("ep_ready", br_ready_o, 1); chk("ep_occ", occ_o, 0);
    cyc;

    // compressed link wrap
    drv(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0);
    @(negedge clk); chk("wr_push", push_o, 1); chk("wr_addr", push_addr_o, 64'h0);
    cyc;
    drv(1, 64'h10, 0, 1, 0, 0);
    @(negedge clk); chk("wr_pv", ret_pred_valid_o, 1); chk("wr_tgt", ret_target_o, 64'h0);
    cyc;

    // overflow
    for (int k = 1; k <= 33; k++) begin
      drv(1, 64'(k) * 64'h100, 1, 0, 0, 0);
      cyc;
    end
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("ov_occ", occ_o, 32);
    cyc;
    for (int k = 33; k >= 2; k--) begin
      drv(1, 64'h8000, 0, 1, 0, 0);
      @(negedge clk); chk("ov_pv", ret_pred_valid_o, 1);
      chk("ov_tgt", ret_target_o, 64'(k) * 64'h100 + 64'h4);
      cyc;
    end
    drv(1, 64'h8000, 0, 1, 0, 0);
    @(negedge clk); chk("ov_last_pv", ret_pred_valid_o, 0); chk("ov_last_pop", pop_o, 0);
    chk("ov_last_occ", occ_o, 0);
    cyc;

    // call+ret serialisation
    drv(1, 64'h1000, 1, 0, 0, 0); cyc;
    drv(1, 64'h2000, 1, 1, 0, 0);
    @(negedge clk); chk("cr0_pop", pop_o, 1); chk("cr0_tgt", ret_target_o, 64'h1004);
    chk("cr0_ready", br_ready_o, 1); chk("cr0_push", push_o, 0);
    cyc;
    drv(1, 64'h5000, 0, 1, 0, 0);
    @(negedge clk); chk("cr1_push", push_o, 1); chk("cr1_addr", push_addr_o, 64'h2004);
    chk("cr1_ready", br_ready_o, 0); chk("cr1_pop", pop_o, 0);
    cyc;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("cr2_ready", br_ready_o, 1); chk("cr2_occ", occ_o, 1);
    cyc;
    drv(1, 64'h5000, 0, 1, 0, 0);
    @(negedge clk); chk("cr3_tgt", ret_target_o, 64'h2004); chk("cr3_pv", ret_pred_valid_o, 1);
    cyc;

    // flush during PUSH_PEND with occ=3
    for (int k = 0; k < 4; k++) begin
      drv(1, 64'h4000 + 64'(k) * 64'h10, 1, 0, 0, 0);
      cyc;
    end
    drv(1, 64'h4100, 1, 1, 0, 0);
    @(negedge clk); chk("fl_pop", pop_o, 1);
    cyc;
    drv(0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("fl_push", push_o, 0); chk("fl_ready", br_ready_o, 0);
    chk("fl_occ", occ_o, 3);
    cyc;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("fl_occ_after", occ_o, 0); chk("fl_ready_after", br_ready_o, 1);
    cyc;
    drv(1, 64'h4200, 0, 1, 0, 0);
    @(negedge clk); chk("fl_ret_pv", ret_pred_valid_o, 0); chk("fl_ret_pop", pop_o, 0);
    cyc;

    // reset in PUSH_PEND loses the pending push
    drv(1, 64'h6000, 1, 0, 0, 0); cyc;
    drv(1, 64'h6100, 1, 1, 0, 0); cyc;
    #2 rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rp_push", push_o, 0); chk("rp_occ", occ_o, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); chk("rp_occ_after", occ_o, 0); chk("rp_ready", br_ready_o, 1);
    cyc;
    drv(1, 64'h6200, 0, 1, 0, 0);
    @(negedge clk); chk("rp_ret_pv", ret_pred_valid_o, 0);
    cyc;

    // randomized traffic, phases biased toward calls, mixed, then returns
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit v, c, r, f;
      logic [63:0] pc;
      ph = (i / 150) % 3;
      v  = ($urandom_range(0, 3) != 0);
      case (ph)
        0:       begin c = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 2); end
        1:       begin c = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1); end
        default: begin c = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 7); end
      endcase
      f  = ($urandom_range(0, 63) == 0);
      pc = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 31) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
      drv(v, pc, c, r, 1'($urandom_range(0, 1)), f);
      cyc;
    end
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) cyc;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
